// File: rtl/block_c.sv
// rtl/block_c.sv - NUM_CH valid/ready inputs, per-channel FIFOs, round-robin merge onto one tagged output
// Optional feature macro: BLOCK_C_PARITY_EN (per-word parity storage, data_par, par_err)
module block_c #(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_CH     = 4,
   parameter int DEPTH      = 4,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_CH-1:0]            data_in_vld,
   output logic [NUM_CH-1:0]            data_in_rdy,
`ifdef BLOCK_C_PARITY_EN
   input  logic [NUM_CH-1:0]            data_in_par,
   output logic                         data_par,
   output logic                         par_err,
`endif
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic [CH_W-1:0]              data_ch,
   output logic                         data_en,
   input  logic                         data_out_rdy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][DEPTH];
   logic [DATA_WIDTH-1:0] mem_d    [NUM_CH][DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q [NUM_CH];
   logic [PTR_W-1:0]      wr_ptr_d [NUM_CH];
   logic [PTR_W-1:0]      rd_ptr_q [NUM_CH];
   logic [PTR_W-1:0]      rd_ptr_d [NUM_CH];
   logic [CNT_W-1:0]      cnt_q    [NUM_CH];
   logic [CNT_W-1:0]      cnt_d    [NUM_CH];
   logic [NUM_CH-1:0]     rdy_q, rdy_d;

   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [CH_W-1:0]       data_ch_q, data_ch_d;
   logic [CH_W-1:0]       last_grant_q, last_grant_d;
   logic                  data_en_q, data_en_d;

   logic [NUM_CH-1:0]     push, pop, nonempty;
   logic                  load, found;
   logic [CH_W-1:0]       grant, cand_idx;
   logic [DATA_WIDTH-1:0] head_word;
   int                    cand;

   assign push = data_in_vld & rdy_q;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         nonempty[i] = (cnt_q[i] != '0);
      end
   end

   // Round-robin search starting just after the last granted channel
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = int'(last_grant_q) + 1 + k;
         if (cand >= NUM_CH) begin
            cand = cand - NUM_CH;
         end
         cand_idx = CH_W'(cand);
         if (!found && nonempty[cand_idx]) begin
            found = 1'b1;
            grant = cand_idx;
         end
      end
   end

   assign load      = (!data_en_q || data_out_rdy) && (|nonempty);
   assign pop       = load ? (NUM_CH'(1) << grant) : '0;
   assign head_word = mem_q[grant][rd_ptr_q[grant]];

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         cnt_d[i]    = cnt_q[i];
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
         end
         if (pop[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
         end
         if (push[i] && !pop[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (!push[i] && pop[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         rdy_d[i] = (cnt_d[i] != CNT_FULL);
      end
   end

   always_comb begin
      data_out_d   = data_out_q;
      data_ch_d    = data_ch_q;
      data_en_d    = data_en_q;
      last_grant_d = last_grant_q;
      if (load) begin
         data_out_d   = head_word;
         data_ch_d    = grant;
         data_en_d    = 1'b1;
         last_grant_d = grant;
      end else if (data_out_rdy) begin
         data_en_d = 1'b0;
      end
   end

   // last_grant resets to the top channel so the first search lands on channel 0
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '{default: '0};
         rd_ptr_q     <= '{default: '0};
         cnt_q        <= '{default: '0};
         rdy_q        <= '0;
         data_out_q   <= '0;
         data_ch_q    <= '0;
         data_en_q    <= 1'b0;
         last_grant_q <= CH_W'(NUM_CH - 1);
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         rdy_q        <= rdy_d;
         data_out_q   <= data_out_d;
         data_ch_q    <= data_ch_d;
         data_en_q    <= data_en_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign data_in_rdy = rdy_q;
   assign data_out    = data_out_q;
   assign data_ch     = data_ch_q;
   assign data_en     = data_en_q;

`ifdef BLOCK_C_PARITY_EN
   logic par_mem_q [NUM_CH][DEPTH];
   logic par_mem_d [NUM_CH][DEPTH];
   logic data_par_q, data_par_d;
   logic par_err_q, par_err_d;
   logic head_par;

   assign head_par = par_mem_q[grant][rd_ptr_q[grant]];

   always_comb begin
      par_mem_d = par_mem_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) begin
            par_mem_d[i][wr_ptr_q[i]] = data_in_par[i];
         end
      end
   end

   // A mismatching word is still forwarded; par_err only flags it for one cycle
   always_comb begin
      data_par_d = data_par_q;
      par_err_d  = 1'b0;
      if (load) begin
         data_par_d = ^head_word;
         par_err_d  = (head_par != (^head_word));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         par_mem_q  <= '{default: 1'b0};
         data_par_q <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         par_mem_q  <= par_mem_d;
         data_par_q <= data_par_d;
         par_err_q  <= par_err_d;
      end
   end

   assign data_par = data_par_q;
   assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_block_c.sv
// tb/tb_block_c.sv - directed vector bench for block_c (DATA_WIDTH=5, NUM_CH=4, DEPTH=4)
module tb_block_c;
   logic        clk;
   logic        rst;
   logic [19:0] din;
   logic [3:0]  vld;
   logic [3:0]  rdy;
   logic [4:0]  dout;
   logic [1:0]  dch;
   logic        den;
   logic        ordy;
`ifdef BLOCK_C_PARITY_EN
   logic [3:0]  din_par;
   logic        dpar;
   logic        perr;
`endif

   int checks = 0;
   int errors = 0;

   block_c #(.DATA_WIDTH(5), .NUM_CH(4), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (din),
      .data_in_vld  (vld),
      .data_in_rdy  (rdy),
`ifdef BLOCK_C_PARITY_EN
      .data_in_par  (din_par),
      .data_par     (dpar),
      .par_err      (perr),
`endif
      .data_out     (dout),
      .data_ch      (dch),
      .data_en      (den),
      .data_out_rdy (ordy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  vld;
      logic [19:0] din;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_en;
      logic        chk_d;
      logic [4:0]  e_out;
      logic [1:0]  e_ch;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   function automatic vec_t v(input logic r, input logic [3:0] vl,
                              input logic [4:0] d3, input logic [4:0] d2,
                              input logic [4:0] d1, input logic [4:0] d0,
                              input logic o, input logic [3:0] er, input logic ee,
                              input logic cd, input logic [4:0] eo, input logic [1:0] ec);
      vec_t t;
      t.rst = r; t.vld = vl; t.din = {d3, d2, d1, d0}; t.ordy = o;
      t.e_rdy = er; t.e_en = ee; t.chk_d = cd; t.e_out = eo; t.e_ch = ec;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [4:0] eo, input logic [1:0] ec);
      chk({name, " en"}, 32'(den), 32'd1);
      chk({name, " data"}, 32'(dout), 32'(eo));
      chk({name, " ch"}, 32'(dch), 32'(ec));
   endtask

   logic [4:0] w1  [4];
   logic [4:0] w3  [2];
   logic [4:0] exp_d [5];
   logic [1:0] exp_c [5];

   initial begin
      // reset with all inputs valid, release, discard check, latency, round robin
      tbl[0]  = v(1, 4'hF, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 1, 4'h0, 0, 1, 5'h00, 2'd0);
      tbl[1]  = v(1, 4'hF, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 1, 4'h0, 0, 1, 5'h00, 2'd0);
      tbl[2]  = v(1, 4'hF, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 1, 4'h0, 0, 1, 5'h00, 2'd0);
      tbl[3]  = v(0, 4'hF, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 1, 4'hF, 0, 0, 5'h00, 2'd0);
      tbl[4]  = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'hF, 0, 0, 5'h00, 2'd0);
      tbl[5]  = v(0, 4'h4, 5'h00, 5'h0A, 5'h00, 5'h00, 1, 4'hF, 0, 0, 5'h00, 2'd0);
      tbl[6]  = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'hF, 1, 1, 5'h0A, 2'd2);
      tbl[7]  = v(0, 4'h1, 5'h00, 5'h00, 5'h00, 5'h1E, 1, 4'hF, 0, 0, 5'h00, 2'd0);
      tbl[8]  = v(1, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'h0, 0, 1, 5'h00, 2'd0);
      tbl[9]  = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 0, 4'hF, 0, 0, 5'h00, 2'd0);
      tbl[10] = v(0, 4'hB, 5'h04, 5'h00, 5'h03, 5'h01, 0, 4'hF, 0, 0, 5'h00, 2'd0);
      tbl[11] = v(0, 4'h9, 5'h05, 5'h00, 5'h00, 5'h02, 0, 4'hF, 1, 1, 5'h01, 2'd0);
      tbl[12] = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 0, 4'hF, 1, 1, 5'h01, 2'd0);
      tbl[13] = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'hF, 1, 1, 5'h03, 2'd1);
      tbl[14] = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'hF, 1, 1, 5'h04, 2'd3);
      tbl[15] = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'hF, 1, 1, 5'h02, 2'd0);
      tbl[16] = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'hF, 1, 1, 5'h05, 2'd3);
      tbl[17] = v(0, 4'h0, 5'h00, 5'h00, 5'h00, 5'h00, 1, 4'hF, 0, 0, 5'h00, 2'd0);

      w1 = '{5'h11, 5'h12, 5'h14, 5'h15};
      w3 = '{5'h1A, 5'h1B};
      exp_d = '{5'h1A, 5'h12, 5'h1B, 5'h14, 5'h15};
      exp_c = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd1};

      rst = 1'b1; vld = '0; din = '0; ordy = 1'b0;
`ifdef BLOCK_C_PARITY_EN
      din_par = '0;
`endif

      for (int n = 0; n < NV; n++) begin
         rst = tbl[n].rst; vld = tbl[n].vld; din = tbl[n].din; ordy = tbl[n].ordy;
         step();
         chk($sformatf("vec%0d rdy", n), 32'(rdy), 32'(tbl[n].e_rdy));
         chk($sformatf("vec%0d en", n), 32'(den), 32'(tbl[n].e_en));
         if (tbl[n].chk_d) begin
            chk($sformatf("vec%0d data", n), 32'(dout), 32'(tbl[n].e_out));
            chk($sformatf("vec%0d ch", n), 32'(dch), 32'(tbl[n].e_ch));
         end
      end

      // output hold with 5'h13 parked while ch1 fills and ch3 receives words
      vld = 4'b0001; din = {5'h00, 5'h00, 5'h00, 5'h13}; ordy = 1'b0;
      step();
      chk("hold pre en", 32'(den), 32'd0);
      vld = 4'b0000; din = '0;
      step();
      chk_out("hold load", 5'h13, 2'd0);
      for (int k = 0; k < 4; k++) begin
         vld = (k < 2) ? 4'b1010 : 4'b0010;
         din = {((k < 2) ? w3[k] : 5'h00), 5'h00, w1[k], 5'h00};
         step();
         chk_out($sformatf("hold fill%0d", k), 5'h13, 2'd0);
         chk($sformatf("fill%0d rdy1", k), 32'(rdy[1]), (k == 3) ? 32'd0 : 32'd1);
         chk($sformatf("fill%0d rdy3", k), 32'(rdy[3]), 32'd1);
      end
      vld = 4'b0010; din = {5'h00, 5'h00, 5'h1F, 5'h00};
      step();
      chk_out("hold fifth", 5'h13, 2'd0);
      chk("fifth rdy1", 32'(rdy[1]), 32'd0);

      // release backpressure: ch1 ready returns on the first pop edge, order is round robin
      vld = 4'b0000; din = '0; ordy = 1'b1;
      step();
      chk_out("drain0", 5'h11, 2'd1);
      chk("drain0 rdy1", 32'(rdy[1]), 32'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk_out($sformatf("drain%0d", k + 1), exp_d[k], exp_c[k]);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         chk($sformatf("drain idle%0d en", k), 32'(den), 32'd0);
      end

`ifdef BLOCK_C_PARITY_EN
      vld = 4'b0001; din = {5'h00, 5'h00, 5'h00, 5'h07}; din_par = 4'b0000;
      step();
      chk("par push err", 32'(perr), 32'd0);
      vld = 4'b0000; din = '0;
      step();
      chk_out("par load", 5'h07, 2'd0);
      chk("par data_par", 32'(dpar), 32'd1);
      chk("par err pulse", 32'(perr), 32'd1);
      step();
      chk("par err clear", 32'(perr), 32'd0);
      chk("par en clear", 32'(den), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
